if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the DLX pipeline; the producer end of the IF→ID interface. It owns the fetch PC and drives word requests to instruction memory through a req/ack handshake. Returned words are buffered in a small FIFO and presented to the decode stage as (instruction, PC, valid). It also applies the jump redirects that decode (`Pc_cmd_id`/`pc_in_ID`) and execute (`pc_cmd_EX`) send back up the pipeline.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2: fetch FIFO entries; allowed range 2..4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address of the request; bits [1:0] always 0.
- `imem_ack`  in  1  memory accepts; `imem_rdata` valid in this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `Pc_cmd_id`  in  1  jump resolved in decode.
- `pc_in_ID`  in  32  decode jump target.
- `pc_cmd_EX`  in  1  branch taken in execute.
- `pc_in_EX`  in  32  execute branch target.
- `stall_ID`  in  1  decode holds its current instruction.
- `instr_ID`  out  32  instruction presented to decode.
- `PC_ID`  out  32  address of `instr_ID`.
- `valid_ID`  out  1  `instr_ID`/`PC_ID` are meaningful.

## Operation
- **Registers:** `fetch_pc` (next address to request), `drop` flag, FIFO entries of {pc, instr}, `count`.
- **Request rule:**
  - `imem_req` = !`reset` && (`count` < `DEPTH` || `drop`).
  - Once raised, `imem_req` and `imem_addr` hold stable until `imem_ack`.
  - `imem_addr` = `fetch_pc`.
- **On ack with no redirect and `drop` = 0:**
  - push {`fetch_pc`, `imem_rdata`} into the FIFO.
  - `fetch_pc` += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- **Head output:**
  - when `count` > 0: `instr_ID`/`PC_ID` show the FIFO head and `valid_ID` = 1.
  - when `count` = 0: `instr_ID` = `NOP_INSTR`, `PC_ID` holds its last value, `valid_ID` = 0.
  - pop when `valid_ID` && !`stall_ID`.
- **EX redirect (`pc_cmd_EX` = 1):**
  - flush the entire FIFO, including the head.
  - `fetch_pc` ← {`pc_in_EX`[31:2], 2'b00}.
  - takes priority over `Pc_cmd_id` and ignores `stall_ID`.
- **ID redirect (`Pc_cmd_id` && !`pc_cmd_EX`):**
  - honoured only if `valid_ID` && !`stall_ID`.
  - the head pops normally; all younger entries are flushed.
  - `fetch_pc` ← {`pc_in_ID`[31:2], 2'b00}.
  - if `stall_ID` = 1, the redirect is ignored; decode re-asserts it.
- **Redirect vs. in-flight request:**
  - Redirect while `imem_req` && !`imem_ack`: set `drop`. The pending request keeps its old address; its ack data is discarded and clears `drop`. The new target is requested the following cycle.
  - Redirect in the same cycle as `imem_ack`: the acked word is discarded, `drop` is not set, and the next request uses the target.
- **Push and pop in the same cycle:** `count` is unchanged.

## Timing
- **Reset values:**
  - `imem_req` = 0, `valid_ID` = 0, `instr_ID` = `NOP_INSTR`, `PC_ID` = 0.
  - `fetch_pc` = `RESET_PC`, `drop` = 0, `count` = 0.
- **First request:** `imem_req` = 1 with `imem_addr` = `RESET_PC` in the first cycle after `reset` deasserts.
- **Latency:** ack in cycle N → `valid_ID` with that word in cycle N+1.
- **Throughput:** with zero-wait memory (ack tied high), one instruction per cycle is sustained.
- **Redirect to target on `instr_ID`:**
  - 2 cycles with zero-wait memory.
  - 2 + remaining wait cycles of the dropped request when one is in flight.
- **Reset mid-request:** all state clears and `imem_req` drops immediately (memory must tolerate an abandoned request).

## Structure
- **Package `dlx_pkg`:**
  - `NOP_INSTR` = 32'h0000_0000.
  - `PC_STEP` = 4.
  - typedef `fetch_entry_t` {logic [31:0] pc; logic [31:0] instr;}.
- **Sub-module `fetch_fifo`:**
  - parameterised by `DEPTH`.
  - ports: push/pop/flush_all/flush_younger, head, count.
- **`if_stage` itself:** PC/drop control and the request logic.

## Test plan
- **Reset, zero-wait memory:** `RESET_PC` = 0x100, ack = 1 → `PC_ID` sequence 0x100, 0x104, 0x108 on consecutive cycles, starting 1 cycle after the first req.
- **Stall backpressure:** `stall_ID` held 4 cycles → `count` reaches 2 and `imem_req` drops; `PC_ID` stays at 0x104; on release, 0x108 and 0x10C follow with no gap or loss.
- **ID redirect:** head 0x108 with `Pc_cmd_id` = 1, target 0x200 → 0x10C is flushed; next `valid_ID` shows `PC_ID` = 0x200 two cycles later.
- **EX redirect colliding with ID redirect:** `pc_cmd_EX` (0x400) and `Pc_cmd_id` (0x200) in the same cycle → head flushed, next valid `PC_ID` = 0x400, 0x200 is never fetched.
- **Drop case:** 3-wait-state memory, redirect to 0x300 one cycle after req@0x110 → req@0x110 stays until ack, its data is never shown, the next req is 0x300.
- **Wrap and alignment:** `pc_in_EX` = 0xFFFF_FFFE → requests 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX front-end types and constants used by the fetch stage.
package dlx_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam int unsigned FIFO_CNT_W  = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} pairs feeding decode.
module fetch_fifo
  import dlx_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  fetch_entry_t          push_data,
  input  logic                  pop,
  input  logic                  flush_all,
  input  logic                  flush_younger,
  output fetch_entry_t          head,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 4) begin : g_depth_check
    $error("fetch_fifo: DEPTH must be in 2..4");
  end

  fetch_entry_t                mem_q [DEPTH];
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [FIFO_CNT_W-1:0]       count_q, count_d;
  logic                        do_push, do_pop, wr_en;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q < FIFO_CNT_W'(DEPTH)) || do_pop);
    wr_en    = 1'b0;
    head     = mem_q[rd_ptr_q];
    count    = count_q;

    if (flush_all) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (flush_younger) begin
      // Keep only the head, and only if it is not leaving this cycle.
      if (do_pop || (count_q == '0)) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
      end else begin
        wr_ptr_d = inc_ptr(rd_ptr_q);
        count_d  = FIFO_CNT_W'(1);
      end
    end else begin
      wr_en = do_push;
      if (do_push) wr_ptr_d = inc_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = inc_ptr(rd_ptr_q);
      count_d = count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/if_stage.sv
// DLX instruction-fetch stage: fetch PC, imem req/ack handshake, redirects
// from decode/execute, and the buffered instruction stream into decode.
module if_stage
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Pc_cmd_id,
  input  logic [31:0] pc_in_ID,
  input  logic        pc_cmd_EX,
  input  logic [31:0] pc_in_EX,
  input  logic        stall_ID,
  output logic [31:0] instr_ID,
  output logic [31:0] PC_ID,
  output logic        valid_ID
);

  logic [31:0]           fetch_pc_q, fetch_pc_d;
  logic [31:0]           redir_pc_q, redir_pc_d;
  logic [31:0]           last_pc_q, last_pc_d;
  logic                  drop_q, drop_d;
  logic [31:0]           target;
  logic                  head_valid, accept;
  logic                  redir_ex, redir_id, redirect;
  logic                  push, pop;
  fetch_entry_t          push_entry, head;
  logic [FIFO_CNT_W-1:0] count;

  always_comb begin
    head_valid = (count != '0);
    imem_req   = !reset && ((count < FIFO_CNT_W'(DEPTH)) || drop_q);
    imem_addr  = fetch_pc_q;
    valid_ID   = head_valid;
    instr_ID   = head_valid ? head.instr : NOP_INSTR;
    PC_ID      = head_valid ? head.pc : last_pc_q;

    accept   = imem_req && imem_ack;
    redir_ex = pc_cmd_EX;
    redir_id = Pc_cmd_id && !pc_cmd_EX && head_valid && !stall_ID;
    redirect = redir_ex || redir_id;
    target   = redir_ex ? align_pc(pc_in_EX) : align_pc(pc_in_ID);

    pop              = head_valid && !stall_ID && !redir_ex;
    push             = accept && !drop_q && !redirect;
    push_entry.pc    = fetch_pc_q;
    push_entry.instr = imem_rdata;

    fetch_pc_d = fetch_pc_q;
    redir_pc_d = redir_pc_q;
    drop_d     = drop_q;
    last_pc_d  = PC_ID;

    // An unacked request must keep its address, so park the target until its ack.
    if (redirect) begin
      if (imem_req && !imem_ack) begin
        drop_d     = 1'b1;
        redir_pc_d = target;
      end else begin
        fetch_pc_d = target;
        drop_d     = 1'b0;
      end
    end else if (accept) begin
      if (drop_q) begin
        fetch_pc_d = redir_pc_q;
        drop_d     = 1'b0;
      end else begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      redir_pc_q <= '0;
      last_pc_q  <= '0;
      drop_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
      last_pc_q  <= last_pc_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fetch_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_data    (push_entry),
    .pop          (pop),
    .flush_all    (redir_ex),
    .flush_younger(redir_id),
    .head         (head),
    .count        (count)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a wait-state-configurable instruction memory.
module tb_if_stage;
  import dlx_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        Pc_cmd_id = 1'b0;
  logic [31:0] pc_in_ID = '0;
  logic        pc_cmd_EX = 1'b0;
  logic [31:0] pc_in_EX = '0;
  logic        stall_ID = 1'b0;
  logic [31:0] instr_ID;
  logic [31:0] PC_ID;
  logic        valid_ID;

  int unsigned waits = 0;
  logic [3:0]  wait_cnt = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // Memory: acks after 'waits' idle cycles of a held request; data = ~addr.
  assign imem_ack   = imem_req && (32'(wait_cnt) >= waits);
  assign imem_rdata = ~imem_addr;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= '0;
    else                       wait_cnt <= wait_cnt + 4'd1;
  end

  if_stage #(
    .RESET_PC(32'h0000_0100),
    .DEPTH   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .Pc_cmd_id (Pc_cmd_id),
    .pc_in_ID  (pc_in_ID),
    .pc_cmd_EX (pc_cmd_EX),
    .pc_in_EX  (pc_in_EX),
    .stall_ID  (stall_ID),
    .instr_ID  (instr_ID),
    .PC_ID     (PC_ID),
    .valid_ID  (valid_ID)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decode-side view: valid flag, PC, and instruction (~pc when valid, NOP otherwise).
  task automatic expect_id(input string tag, input logic v, input logic [31:0] pc);
    check_eq({tag, ".valid"}, 32'(valid_ID), 32'(v));
    check_eq({tag, ".pc"}, PC_ID, pc);
    check_eq({tag, ".instr"}, instr_ID, v ? ~pc : NOP_INSTR);
  endtask

  task automatic expect_req(input string tag, input logic r, input logic [31:0] addr);
    check_eq({tag, ".req"}, 32'(imem_req), 32'(r));
    if (r) check_eq({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    expect_req("rst", 1'b0, 32'h0);
    expect_id("rst", 1'b0, 32'h0);
    reset = 1'b0;
    #1 expect_req("first_req", 1'b1, 32'h100);

    // Zero-wait streaming
    @(negedge clk); expect_id("seq0", 1'b1, 32'h100);
    @(negedge clk); expect_id("seq1", 1'b1, 32'h104);
    stall_ID = 1'b1;

    // Backpressure: FIFO fills, request drops, head holds
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_id("stall", 1'b1, 32'h104);
      expect_req("stall", 1'b0, 32'h0);
    end
    stall_ID = 1'b0;
    @(negedge clk); expect_id("rel0", 1'b1, 32'h108);
    expect_req("rel0", 1'b1, 32'h10C);
    @(negedge clk); expect_id("rel1", 1'b1, 32'h10C);

    // ID redirect while stalled is ignored
    Pc_cmd_id = 1'b1; pc_in_ID = 32'h200; stall_ID = 1'b1;
    @(negedge clk); expect_id("id_stalled", 1'b1, 32'h10C);
    expect_req("id_stalled", 1'b0, 32'h0);
    stall_ID = 1'b0;
    @(negedge clk); expect_id("id_redir", 1'b0, 32'h10C);
    expect_req("id_redir", 1'b1, 32'h200);
    Pc_cmd_id = 1'b0;
    @(negedge clk); expect_id("id_target", 1'b1, 32'h200);

    // EX and ID redirect together, decode stalled: EX wins
    pc_cmd_EX = 1'b1; pc_in_EX = 32'h400;
    Pc_cmd_id = 1'b1; pc_in_ID = 32'h200; stall_ID = 1'b1;
    @(negedge clk); expect_id("ex_prio", 1'b0, 32'h200);
    expect_req("ex_prio", 1'b1, 32'h400);
    pc_cmd_EX = 1'b0; Pc_cmd_id = 1'b0; stall_ID = 1'b0;
    @(negedge clk); expect_id("ex_target", 1'b1, 32'h400);

    // Drop case: slow memory, redirect while req@0x110 pending
    pc_cmd_EX = 1'b1; pc_in_EX = 32'h110;
    @(negedge clk); expect_id("to110", 1'b0, 32'h400);
    expect_req("to110", 1'b1, 32'h110);
    pc_cmd_EX = 1'b0; waits = 3;
    @(negedge clk); expect_req("wait1", 1'b1, 32'h110);
    pc_cmd_EX = 1'b1; pc_in_EX = 32'h300;
    @(negedge clk); expect_req("drop_hold", 1'b1, 32'h110);
    expect_id("drop_hold", 1'b0, 32'h400);
    pc_cmd_EX = 1'b0;
    @(negedge clk); expect_req("drop_ack", 1'b1, 32'h110);
    @(negedge clk); expect_id("dropped", 1'b0, 32'h400);
    expect_req("dropped", 1'b1, 32'h300);
    waits = 0;
    @(negedge clk); expect_id("drop_target", 1'b1, 32'h300);

    // Wrap and alignment
    pc_cmd_EX = 1'b1; pc_in_EX = 32'hFFFF_FFFE;
    @(negedge clk); expect_req("wrap0", 1'b1, 32'hFFFF_FFFC);
    expect_id("wrap0", 1'b0, 32'h300);
    pc_cmd_EX = 1'b0;
    @(negedge clk); expect_id("wrap1", 1'b1, 32'hFFFF_FFFC);
    expect_req("wrap1", 1'b1, 32'h0);
    @(negedge clk); expect_id("wrap2", 1'b1, 32'h0);

    // Reset in the middle of a pending request
    waits = 3; reset = 1'b1;
    #1 expect_req("rst_mid", 1'b0, 32'h0);
    @(negedge clk); expect_id("rst_mid", 1'b0, 32'h0);
    expect_req("rst_held", 1'b0, 32'h0);
    reset = 1'b0; waits = 0;
    #1 expect_req("rst_restart", 1'b1, 32'h100);
    @(negedge clk); expect_id("rst_restart", 1'b1, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
